// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_pkg
// Purpose  : Shared widths, the PC register index and the writeback queue
//            entry type for the register-file writeback controller.
// Contents : REG_ADDR_W, DATA_W, PC_REG_IDX, COUNT_W, STALL_W, wb_entry_t
// Revision : 1.0 - initial release
// ============================================================================
package rf_wb_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam int COUNT_W    = 4;
  localparam int STALL_W    = 8;

  // Register index 0 shares its write port with the PC update path.
  localparam logic [REG_ADDR_W-1:0] PC_REG_IDX = 3'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage : rf_wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Circular FIFO holding pending writeback entries. Besides the
//            head it exposes every slot in age order (index 0 = oldest) with
//            a valid mask so the controller can search pending writes.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            push, push_entry - enqueue (caller guarantees count < DEPTH)
//            pop              - dequeue head (caller guarantees count > 0)
//            head             - oldest entry
//            count            - occupied entries
//            view, view_valid - all slots ordered oldest..youngest
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  output wb_entry_t               head,
  output logic [COUNT_W-1:0]      count,
  output wb_entry_t [DEPTH-1:0]   view,
  output logic [DEPTH-1:0]        view_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]    count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    logic [PTR_W-1:0] slot_idx;
    assign slot_idx      = rd_ptr_q + PTR_W'(i);
    assign view[i]       = mem_q[slot_idx];
    assign view_valid[i] = (count_q > COUNT_W'(i));
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/rf_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_ctrl
// Purpose  : Register-file writeback controller. Queues writeback requests,
//            drains one per cycle into a registered write port, and holds a
//            request to register 0 while the PC port is writing the same
//            cycle (counting those stall cycles, saturating). Optionally
//            offers a combinational forwarding lookup of pending writes.
// Config   : RF_WB_FWD_EN - defined: forwarding lookup enabled;
//                           undefined: fwd_hit/fwd_data tied to 0.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            wb_valid/wb_ready/wb_addr/wb_data - writeback request handshake
//            pc_valid/pc_data            - PC update request (always taken)
//            rf_a3/rf_d3/rf_d3_en        - register-file write port
//            pc_en/rf_pc_w               - register-file PC write port
//            fwd_addr/fwd_hit/fwd_data   - forwarding lookup
//            count                       - queue occupancy
//            stall_cnt                   - saturating PC-conflict stall count
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_ctrl
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  pc_valid,
  input  logic [DATA_W-1:0]     pc_data,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0]     rf_d3,
  output logic                  rf_d3_en,
  output logic                  pc_en,
  output logic [DATA_W-1:0]     rf_pc_w,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [COUNT_W-1:0]    count,
  output logic [STALL_W-1:0]    stall_cnt
);

  wb_entry_t             head;
  wb_entry_t             push_entry;
  wb_entry_t [DEPTH-1:0] q_view;
  logic [DEPTH-1:0]      q_view_valid;
  logic [COUNT_W-1:0]    q_count;
  logic                  q_nonempty;
  logic                  push;
  logic                  pop;
  logic                  conflict;

  logic [REG_ADDR_W-1:0] rf_a3_q,     rf_a3_d;
  logic [DATA_W-1:0]     rf_d3_q,     rf_d3_d;
  logic                  rf_d3_en_q,  rf_d3_en_d;
  logic                  pc_en_q,     pc_en_d;
  logic [DATA_W-1:0]     rf_pc_w_q,   rf_pc_w_d;
  logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;

  // Readiness depends only on occupancy, never on a same-cycle pop, so
  // there is no combinational path from pc_valid to wb_ready.
  assign wb_ready   = (q_count < COUNT_W'(DEPTH));
  assign push       = wb_valid && wb_ready;
  assign q_nonempty = (q_count != '0);
  assign push_entry = '{addr: wb_addr, data: wb_data};

  // Register 0 and the PC share a write port: the PC wins and the head waits.
  assign conflict = q_nonempty && (head.addr == PC_REG_IDX) && pc_valid;
  assign pop      = q_nonempty && !conflict;

  wb_fifo #(
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (q_count),
    .view       (q_view),
    .view_valid (q_view_valid)
  );

  always_comb begin
    rf_d3_en_d  = pop;
    rf_a3_d     = rf_a3_q;
    rf_d3_d     = rf_d3_q;
    pc_en_d     = pc_valid;
    rf_pc_w_d   = rf_pc_w_q;
    stall_cnt_d = stall_cnt_q;
    if (pop) begin
      rf_a3_d = head.addr;
      rf_d3_d = head.data;
    end
    if (pc_valid) begin
      rf_pc_w_d = pc_data;
    end
    if (conflict && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_a3_q     <= '0;
      rf_d3_q     <= '0;
      rf_d3_en_q  <= 1'b0;
      pc_en_q     <= 1'b0;
      rf_pc_w_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      rf_a3_q     <= rf_a3_d;
      rf_d3_q     <= rf_d3_d;
      rf_d3_en_q  <= rf_d3_en_d;
      pc_en_q     <= pc_en_d;
      rf_pc_w_q   <= rf_pc_w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rf_a3     = rf_a3_q;
  assign rf_d3     = rf_d3_q;
  assign rf_d3_en  = rf_d3_en_q;
  assign pc_en     = pc_en_q;
  assign rf_pc_w   = rf_pc_w_q;
  assign stall_cnt = stall_cnt_q;
  assign count     = q_count;

`ifdef RF_WB_FWD_EN
  // The output stage is the oldest candidate; queue slots are scanned
  // oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (rf_d3_en_q && (rf_a3_q == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = rf_d3_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (q_view_valid[i] && (q_view[i].addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_view[i].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr, q_view, q_view_valid};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule : rf_wb_ctrl
`default_nettype wire

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..8.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 wb_valid  input  1  writeback request valid.
REQ-005 wb_ready  output  1  request accepted at edge when wb_valid && wb_ready.
REQ-006 wb_addr  input  3  destination register index.
REQ-007 wb_data  input  16  write data.
REQ-008 pc_valid  input  1  PC update request this cycle; always accepted.
REQ-009 pc_data  input  16  new PC value.
REQ-010 rf_a3  output  3  register-file write address.
REQ-011 rf_d3  output  16  register-file write data.
REQ-012 rf_d3_en  output  1  register-file write enable.
REQ-013 pc_en  output  1  register-file PC write enable.
REQ-014 rf_pc_w  output  16  register-file PC write value.
REQ-015 fwd_addr  input  3  forwarding lookup address.
REQ-016 fwd_hit  output  1  pending write to fwd_addr exists.
REQ-017 fwd_data  output  16  youngest pending data for fwd_addr.
REQ-018 count  output  4  occupied queue entries.
REQ-019 stall_cnt  output  8  saturating count of PC-conflict stall cycles.

Function
REQ-020 wb_ready SHALL equal (count < DEPTH), independent of same-cycle pop.
REQ-021 Accepted requests SHALL be queued FIFO; push and pop in one cycle leave count unchanged; pointers wrap modulo DEPTH.
REQ-022 Each cycle with count > 0 the head SHALL pop into the output stage (rf_d3_en<=1, rf_a3<=addr, rf_d3<=data), unless head addr == 0 and pc_valid == 1.
REQ-023 In that conflict case the head SHALL be held, rf_d3_en<=0, and stall_cnt SHALL increment, saturating at 255.
REQ-024 With no pop, rf_d3_en SHALL be 0 and rf_a3/rf_d3 SHALL hold their previous values.
REQ-025 pc_en SHALL be registered from pc_valid; rf_pc_w SHALL load pc_data when pc_valid, else hold.
REQ-026 rf_d3_en and pc_en SHALL never both be 1 while rf_a3 == 0.
REQ-027 Latency: request accepted at edge E0 into an empty queue drives rf_d3_en at edge E1; register file updates at E2.
REQ-028 A request arriving when the queue is empty SHALL NOT bypass the queue.
REQ-029 fwd_hit/fwd_data SHALL be combinational over valid queue entries plus the output stage when rf_d3_en == 1; youngest match wins; output stage is oldest.
REQ-030 With no match, fwd_hit SHALL be 0 and fwd_data SHALL be 0.

Reset
REQ-031 On rst_n low: queue empty, count 0, rf_d3_en 0, pc_en 0, rf_a3 0, rf_d3 0, rf_pc_w 0, stall_cnt 0, wb_ready 1.
REQ-032 Reset mid-operation SHALL discard all pending entries with no further rf_d3_en pulse.

Configuration
REQ-033 Macro RF_WB_FWD_EN defined: forwarding per REQ-029/030.
REQ-034 Macro RF_WB_FWD_EN undefined: no lookup logic; fwd_hit and fwd_data tied to 0; fwd_addr ignored.

Structure
REQ-035 Package rf_wb_pkg SHALL hold REG_ADDR_W=3, DATA_W=16, PC_REG_IDX=3'd0, and the queue entry typedef {addr, data}.
REQ-036 Queue storage and pointers SHALL be a sub-module wb_fifo; the conflict arbitration, output stage and forwarding stay in rf_wb_ctrl.

Verification
REQ-037 Push (3, 0x1234) into the empty queue at E0 -> rf_d3_en=1, rf_a3=3, rf_d3=0x1234 after E1; count returns to 0.
REQ-038 Push 5 back-to-back requests while pc_valid=0 and head addr 0 (DEPTH=4), with pops active -> no entry lost; order preserved; wb_ready=0 only when count=4.
REQ-039 Head (0, 0xAAAA) with pc_valid=1 for 3 cycles, pc_data=0x0040 -> pc_en each cycle, rf_d3_en=0, stall_cnt=3; head issues on the first cycle with pc_valid=0.
REQ-040 Queue holds (2, 0x0011) then (2, 0x0022); fwd_addr=2 -> fwd_hit=1, fwd_data=0x0022; fwd_addr=6 -> fwd_hit=0, fwd_data=0; without RF_WB_FWD_EN, always 0.
REQ-041 Assert rst_n low with 3 entries pending -> outputs per REQ-031 immediately; no rf_d3_en after release.
REQ-042 Hold the conflict for 300 cycles -> stall_cnt saturates at 255.
